hilo_md_unit: RTL and testbench

- Multiply/divide sequencing unit and HI/LO register file for the multicycle 54-instruction CPU.
- Sits between the control FSM / register-file read stage and the iterative 32-cycle divider.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and latches and holds the divider operands.
- Drives the divider's ena/start handshake, waits out its busy window, captures quotient→LO and remainder→HI, and stalls the control FSM meanwhile.

---
 rtl/hilo_md_unit.sv | 130 +++++++++++++
 tb/tb_hilo_md_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_md_unit.sv
// hilo_md_unit: HI/LO register file and multiply/divide sequencer.
// Multiplies and HI/LO moves finish at the accept edge. Divides with a
// nonzero divisor go to the external iterative divider, and the control
// FSM is stalled until the quotient and remainder have been captured.
module hilo_md_unit #(
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_signed,
    output logic        div_ena,
    output logic        div_start,
    input  logic        div_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        div_err
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    localparam int unsigned CW = (DIV_TIMEOUT < 2) ? 1 : $clog2(DIV_TIMEOUT);
    localparam logic [CW-1:0] RUN_LAST = CW'(DIV_TIMEOUT - 1);

    logic [2:0]    state;
    logic [CW-1:0] run_cnt;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   mul_s;
    logic [63:0]   mul_u;

    // Products. The low 64 bits of the product of the sign-extended
    // operands equal the signed 64-bit product.
    always_comb begin
        ext_a = {{32{rs_data[31]}}, rs_data};
        ext_b = {{32{rt_data[31]}}, rt_data};
        mul_s = ext_a * ext_b;
        mul_u = {32'd0, rs_data} * {32'd0, rt_data};
    end

    // The divider handshake is decoded straight from the state.
    assign stall     = (state != S_IDLE);
    assign div_ena   = (state != S_IDLE);
    assign div_start = (state == S_START);

    // Sequencer FSM, HI/LO update and the latched divider operands.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            run_cnt      <= '0;
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
            div_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT:  {hi, lo} <= mul_s;
                            OP_MULTU: {hi, lo} <= mul_u;
                            OP_MTHI:  hi <= rs_data;
                            OP_MTLO:  lo <= rs_data;
                            OP_DIV, OP_DIVU: begin
                                div_err <= 1'b0;
                                if (rt_data == '0) begin
                                    hi <= rs_data;
                                    lo <= '1;
                                end else begin
                                    div_dividend <= rs_data;
                                    div_divisor  <= rt_data;
                                    div_signed   <= (op == OP_DIV);
                                    state        <= S_START;
                                end
                            end
                            OP_NOP:  ;
                            default: ;
                        endcase
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (div_busy) begin
                        run_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!div_busy) begin
                        state <= S_CAPTURE;
                    end else if (run_cnt == RUN_LAST) begin
                        div_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    hi    <= div_r;
                    lo    <= div_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// tb_hilo_md_unit: directed and randomized checks of hilo_md_unit against
// an arithmetic HI/LO reference model, with a behavioural divider attached.
module tb_hilo_md_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_signed;
    logic        div_ena;
    logic        div_start;
    logic        div_busy;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        div_err;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_err = 1'b0;

    logic        stuck = 1'b0;
    logic [5:0]  dcnt;

    hilo_md_unit #(.DIV_TIMEOUT(40)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_ena(div_ena), .div_start(div_start),
        .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
        .hi(hi), .lo(lo), .stall(stall), .div_err(div_err)
    );

    always #5 clock = ~clock;

    // Returns {remainder, quotient}, truncating toward zero.
    function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (sb == 0) return '0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural divider: busy rises on the edge that samples start and
    // stays up 31 cycles (forever when stuck); results only while enabled.
    always_ff @(posedge clock) begin
        if (reset)                       dcnt <= '0;
        else if (div_ena && div_start)   dcnt <= 6'd31;
        else if (dcnt != 0 && !stuck)    dcnt <= dcnt - 1'b1;
    end
    assign div_busy = (dcnt != 0);
    always_comb begin
        {div_r, div_q} = {32'hDEADBEEF, 32'hDEADBEEF};
        if (div_ena) {div_r, div_q} = divide(div_dividend, div_divisor, div_signed);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issues one op, follows any stall and checks the resulting state.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_timeout, input bit inject);
        logic [31:0] e_hi, e_lo;
        logic [63:0] p, qr;
        bit longop;
        int stall_cnt, start_cnt, gap, cyc;
        e_hi = m_hi; e_lo = m_lo; longop = 0;
        stall_cnt = 0; start_cnt = 0; gap = 0; cyc = 0;
        case (o)
            3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {e_hi, e_lo} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {e_hi, e_lo} = p; end
            3'd3, 3'd4: begin
                m_err = 1'b0;
                if (b == 0) begin
                    e_hi = a; e_lo = 32'hFFFFFFFF;
                end else begin
                    longop = 1;
                    if (expect_timeout) m_err = 1'b1;
                    else begin qr = divide(a, b, o == 3'd3); e_hi = qr[63:32]; e_lo = qr[31:0]; end
                end
            end
            3'd5: e_hi = a;
            3'd6: e_lo = a;
            default: ;
        endcase
        op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
        tick;
        op_valid = 1'b0;
        check("stall_first", 32'(stall), 32'(longop));
        check("start_first", 32'(div_start), 32'(longop));
        if (longop) begin
            check("dividend", div_dividend, a);
            check("divisor", div_divisor, b);
            check("div_signed", 32'(div_signed), 32'(o == 3'd3));
        end
        while (stall === 1'b1 && cyc < 100) begin
            stall_cnt++;
            if (div_start) start_cnt++;
            if (!div_ena) gap++;
            if (inject && cyc == 4) begin
                op_valid = 1'b1; op = 3'd5; rs_data = 32'h55;
            end else begin
                op_valid = 1'b0;
            end
            tick;
            cyc++;
        end
        op_valid = 1'b0;
        if (longop) begin
            check("stall_cycles", 32'(stall_cnt), expect_timeout ? 32'd42 : 32'd34);
            check("start_cycles", 32'(start_cnt), 32'd1);
            check("ena_gap", 32'(gap), 32'd0);
        end
        check("hi", hi, e_hi);
        check("lo", lo, e_lo);
        check("div_err", 32'(div_err), 32'(m_err));
        check("ena_idle", 32'(div_ena), 32'd0);
        m_hi = e_hi; m_lo = e_lo;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        tick; tick;
        reset = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ena", 32'(div_ena), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_err", 32'(div_err), 32'd0);
        check("rst_dividend", div_dividend, 32'd0);
        check("rst_divisor", div_divisor, 32'd0);
        check("rst_signed", 32'(div_signed), 32'd0);

        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, 0);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        do_op(3'd4, 32'd100, 32'd7, 0, 1);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        do_op(3'd3, 32'h1234, 32'd0, 0, 0);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'hFFFFFFFF);
        do_op(3'd5, 32'hA5A5A5A5, 32'd0, 0, 0);
        do_op(3'd6, 32'h5A5A5A5A, 32'd0, 0, 0);
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0);

        // Reset in cycle 10 of a divide.
        op_valid = 1'b1; op = 3'd3; rs_data = 32'd1000; rt_data = 32'd3;
        tick;
        op_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        check("mid_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_ena", 32'(div_ena), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        m_hi = '0; m_lo = '0; m_err = 1'b0;

        do_op(3'd5, 32'h11112222, 32'd0, 0, 0);
        do_op(3'd6, 32'h33334444, 32'd0, 0, 0);
        stuck = 1'b1;
        do_op(3'd3, 32'd50, 32'd5, 1, 0);
        stuck = 1'b0;
        check("timeout_err", 32'(div_err), 32'd1);

        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb & 32'hFF;
            do_op(ro, ra, rb, 0, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
